// File: rtl/spi_slave_core.sv
// SPI responder: oversamples sclk/cs/mosi in the clk domain, shifts MSB first,
// and offers a one-deep TX holding register plus a single-cycle RX strobe.
module spi_slave_core #(
  parameter int unsigned DWIDTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sclk,
  input  logic              cs,
  input  logic              mosi,
  output logic              miso,
  output logic              miso_oe,
  input  logic [DWIDTH-1:0] tx_data,
  input  logic              tx_we,
  output logic              tx_ready,
  output logic [DWIDTH-1:0] rx_data,
  output logic              rx_valid,
  output logic              underrun,
  output logic              busy
);

  localparam int unsigned CW = (DWIDTH > 2) ? $clog2(DWIDTH) : 1;

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t              state;
  logic                sclk_s1, sclk_s2, sclk_s3;
  logic                cs_s1, cs_s2, cs_s3;
  logic                mosi_s1, mosi_s2;
  logic [DWIDTH-1:0]   tx_hold;
  logic [DWIDTH-1:0]   tx_shift;
  logic [DWIDTH-2:0]   rx_shift;
  logic [CW-1:0]       bit_cnt;
  logic                word_done;

  logic                sclk_rise, sclk_fall, cs_fall, cs_rise;
  logic                load_now;
  logic [DWIDTH-1:0]   load_val;
  logic [DWIDTH-1:0]   rx_next;

  assign sclk_rise = sclk_s2 & ~sclk_s3;
  assign sclk_fall = ~sclk_s2 & sclk_s3;
  assign cs_fall   = ~cs_s2 & cs_s3;
  assign cs_rise   = cs_s2 & ~cs_s3;

  // Shifter reload happens at frame start and on the falling edge after a word boundary.
  assign load_now = ((state == IDLE) && cs_fall) ||
                    ((state == ACTIVE) && !cs_rise && sclk_fall && word_done);
  assign load_val = tx_ready ? '0 : tx_hold;
  assign rx_next  = {rx_shift, mosi_s2};

  // miso is the shifter MSB directly; the shifter is cleared whenever the frame ends.
  assign miso = tx_shift[DWIDTH-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      sclk_s1   <= 1'b0;
      sclk_s2   <= 1'b0;
      sclk_s3   <= 1'b0;
      cs_s1     <= 1'b0;
      cs_s2     <= 1'b0;
      cs_s3     <= 1'b0;
      mosi_s1   <= 1'b0;
      mosi_s2   <= 1'b0;
      tx_hold   <= '0;
      tx_shift  <= '0;
      rx_shift  <= '0;
      bit_cnt   <= '0;
      word_done <= 1'b0;
      miso_oe   <= 1'b0;
      tx_ready  <= 1'b1;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      underrun  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      sclk_s1  <= sclk;
      sclk_s2  <= sclk_s1;
      sclk_s3  <= sclk_s2;
      cs_s1    <= cs;
      cs_s2    <= cs_s1;
      cs_s3    <= cs_s2;
      mosi_s1  <= mosi;
      mosi_s2  <= mosi_s1;
      rx_valid <= 1'b0;
      underrun <= 1'b0;

      // A shifter load consumes the old holding contents; a concurrent write is dropped.
      if (load_now) begin
        tx_shift <= load_val;
        underrun <= tx_ready;
        tx_ready <= 1'b1;
      end else if (tx_we && tx_ready) begin
        tx_hold  <= tx_data;
        tx_ready <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (cs_fall) begin
            state     <= ACTIVE;
            bit_cnt   <= '0;
            busy      <= 1'b0;
            word_done <= 1'b0;
            miso_oe   <= 1'b1;
          end
        end
        ACTIVE: begin
          if (cs_rise) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            busy      <= 1'b0;
            word_done <= 1'b0;
            tx_shift  <= '0;
            miso_oe   <= 1'b0;
          end else begin
            if (sclk_rise) begin
              rx_shift <= rx_next[DWIDTH-2:0];
              if (bit_cnt == CW'(DWIDTH - 1)) begin
                bit_cnt   <= '0;
                busy      <= 1'b0;
                word_done <= 1'b1;
                rx_data   <= rx_next;
                rx_valid  <= 1'b1;
              end else begin
                bit_cnt <= bit_cnt + CW'(1);
                busy    <= 1'b1;
              end
            end
            if (sclk_fall) begin
              if (word_done) begin
                word_done <= 1'b0;
              end else begin
                tx_shift <= {tx_shift[DWIDTH-2:0], 1'b0};
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
